// File: rtl/memory_arbiter_pkg.sv
// memory_arbiter_pkg: shared types for the memory arbiter (register word, FSM state, grant owner)
package memory_arbiter_pkg;
    typedef logic [31:0] regval_t;
    typedef enum logic [1:0] {IDLE, READ_I, READ_D, WRITE} arb_state_t;
    typedef enum logic [1:0] {OWN_I, OWN_D_RD, OWN_D_WR} arb_owner_t;
    localparam int NUM_REQ = 3;
endpackage

// File: rtl/memory_arbiter_if.sv
// memory_arbiter_if: fetch/load/store request channels plus the shared memory port; master = arbiter side, slave = core/memory side
interface memory_arbiter_if #(parameter int ADDR_WIDTH = 25);
    import memory_arbiter_pkg::*;
    regval_t                 ia, iv, da_in, dv_in, da_out, dv_out, mem_write_data, mem_read_data;
    logic                    ia_enable, iv_valid, da_in_enable, dv_in_valid, da_out_enable, dv_out_valid;
    logic [ADDR_WIDTH-1:0]   mem_address;
    logic                    mem_read_n, mem_write_n, mem_data_ready_n, mem_data_written_n, bus_error;
    modport master (
        input  ia, ia_enable, da_in, da_in_enable, da_out, dv_out, da_out_enable,
               mem_read_data, mem_data_ready_n, mem_data_written_n,
        output iv, iv_valid, dv_in, dv_in_valid, dv_out_valid,
               mem_address, mem_read_n, mem_write_n, mem_write_data, bus_error
    );
    modport slave (
        output ia, ia_enable, da_in, da_in_enable, da_out, dv_out, da_out_enable,
               mem_read_data, mem_data_ready_n, mem_data_written_n,
        input  iv, iv_valid, dv_in, dv_in_valid, dv_out_valid,
               mem_address, mem_read_n, mem_write_n, mem_write_data, bus_error
    );
endinterface

// File: rtl/memory_arbiter_arb_select.sv
// arb_select: one-hot grant from masked fetch/load/store requests, store > load > fetch unless the starve force hands it to fetch
module arb_select
    import memory_arbiter_pkg::*;
(
    input  logic               fetch_i,
    input  logic               load_i,
    input  logic               store_i,
    input  logic               force_i,
    output logic [NUM_REQ-1:0] grant_o
);
    logic forced;
    always_comb begin
        forced            = force_i & fetch_i;
        grant_o           = '0;
        grant_o[OWN_D_WR] = store_i & ~forced;
        grant_o[OWN_D_RD] = load_i & ~store_i & ~forced;
        grant_o[OWN_I]    = fetch_i & (forced | ~(store_i | load_i));
    end
endmodule

// File: rtl/memory_arbiter.sv
// memory_arbiter: serialises fetch/load/store onto one memory port (clock, reset_n, bus = memory_arbiter_if.master) with starvation guard and timeout
module memory_arbiter
    import memory_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH     = 25,
    parameter int STARVE_LIMIT   = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input logic              clock,
    input logic              reset_n,
    memory_arbiter_if.master bus
);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    arb_state_t            state_q;
    logic [SW-1:0]         starve_cnt_q;
    logic [TW-1:0]         tmo_cnt_q;
    logic [ADDR_WIDTH-1:0] mem_address_q;
    regval_t               mem_write_data_q, iv_q, dv_in_q, rd_data;
    logic                  mem_read_n_q, mem_write_n_q, iv_valid_q, dv_in_valid_q, dv_out_valid_q, bus_error_q;
    logic [NUM_REQ-1:0]    grant;
    logic [ADDR_WIDTH-1:2] grant_addr;
    logic                  done, expired;
    arb_select u_select (
        .fetch_i (bus.ia_enable & ~iv_valid_q),
        .load_i  (bus.da_in_enable & ~dv_in_valid_q),
        .store_i (bus.da_out_enable & ~dv_out_valid_q),
        .force_i (starve_cnt_q >= SW'(STARVE_LIMIT)),
        .grant_o (grant)
    );
    always_comb begin
        grant_addr = grant[OWN_D_WR] ? bus.da_out[ADDR_WIDTH-1:2] :
                     grant[OWN_D_RD] ? bus.da_in[ADDR_WIDTH-1:2] : bus.ia[ADDR_WIDTH-1:2];
        done       = state_q == WRITE ? ~bus.mem_data_written_n : (state_q != IDLE) & ~bus.mem_data_ready_n;
        expired    = (state_q != IDLE) && tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1);
        rd_data    = done ? bus.mem_read_data : '0;
    end
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q          <= IDLE;
            starve_cnt_q     <= '0;
            tmo_cnt_q        <= '0;
            mem_address_q    <= '0;
            mem_write_data_q <= '0;
            iv_q             <= '0;
            dv_in_q          <= '0;
            mem_read_n_q     <= 1'b1;
            mem_write_n_q    <= 1'b1;
            iv_valid_q       <= 1'b0;
            dv_in_valid_q    <= 1'b0;
            dv_out_valid_q   <= 1'b0;
            bus_error_q      <= 1'b0;
        end else begin
            iv_valid_q     <= 1'b0;
            dv_in_valid_q  <= 1'b0;
            dv_out_valid_q <= 1'b0;
            if (state_q == IDLE) begin
                tmo_cnt_q <= '0;
                if (|grant) begin
                    state_q       <= grant[OWN_I] ? READ_I : grant[OWN_D_RD] ? READ_D : WRITE;
                    mem_address_q <= {grant_addr, 2'b00};
                    mem_read_n_q  <= grant[OWN_D_WR];
                    mem_write_n_q <= ~grant[OWN_D_WR];
                    if (grant[OWN_D_WR]) mem_write_data_q <= bus.dv_out;
                    // saturating: once at the limit the force bit holds until fetch is served
                    starve_cnt_q  <= grant[OWN_I] ? '0 :
                                     (bus.ia_enable && starve_cnt_q < SW'(STARVE_LIMIT)) ? starve_cnt_q + 1'b1 : starve_cnt_q;
                end
            end else begin
                tmo_cnt_q <= tmo_cnt_q + 1'b1;
                if (done || expired) begin
                    state_q       <= IDLE;
                    mem_read_n_q  <= 1'b1;
                    mem_write_n_q <= 1'b1;
                    bus_error_q   <= bus_error_q | ~done;
                    if (state_q == READ_I) begin
                        iv_q       <= rd_data;
                        iv_valid_q <= 1'b1;
                    end
                    if (state_q == READ_D) begin
                        dv_in_q       <= rd_data;
                        dv_in_valid_q <= 1'b1;
                    end
                    if (state_q == WRITE) dv_out_valid_q <= 1'b1;
                end
            end
        end
    end
    assign bus.mem_address    = mem_address_q;
    assign bus.mem_write_data = mem_write_data_q;
    assign bus.mem_read_n     = mem_read_n_q;
    assign bus.mem_write_n    = mem_write_n_q;
    assign bus.iv             = iv_q;
    assign bus.iv_valid       = iv_valid_q;
    assign bus.dv_in          = dv_in_q;
    assign bus.dv_in_valid    = dv_in_valid_q;
    assign bus.dv_out_valid   = dv_out_valid_q;
    assign bus.bus_error      = bus_error_q;
endmodule

// File: doc/memory_arbiter.md
# memory_arbiter

Shares one word-wide memory master port among the core's three request channels: instruction fetch, data read and data write. It sits between `core` and the system interconnect, replacing three separate master ports with one. It serialises requests by fixed priority with a fetch anti-starvation counter. A timeout guards against a hung memory.

## Interface
- `ADDR_WIDTH`, 25, memory byte-address width; the two LSBs are always driven 0.
- `STARVE_LIMIT`, 4, number of consecutive data grants made while a fetch is pending before the fetch is forced to win.
- `TIMEOUT_CYCLES`, 1024, maximum wait for a memory response before the transaction is aborted.
- `clock`  in  1  single clock; all state changes on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `ia`, `ia_enable`  in  32, 1  fetch address and fetch request.
- `iv`, `iv_valid`  out  32, 1  fetch data and a one-cycle completion pulse.
- `da_in`, `da_in_enable`  in  32, 1  load address and load request.
- `dv_in`, `dv_in_valid`  out  32, 1  load data and a one-cycle completion pulse.
- `da_out`, `dv_out`, `da_out_enable`  in  32, 32, 1  store address, store data and store request.
- `dv_out_valid`  out  1  one-cycle store completion pulse.
- `mem_address`  out  ADDR_WIDTH  `{addr[ADDR_WIDTH-1:2], 2'b00}` of the granted requester.
- `mem_read_n`, `mem_write_n`  out  1  active-low read and write strobes.
- `mem_write_data`  out  32  store data.
- `mem_read_data`  in  32  read data, valid while `mem_data_ready_n` is 0.
- `mem_data_ready_n`, `mem_data_written_n`  in  1  active-low read and write completions.
- `bus_error`  out  1  sticky flag, set on any timeout.

## Operation
- **Requester rule.** A requester holds its enable and address (and, for a store, its data) stable until its valid pulse. It drops the enable in the following cycle unless it is issuing a new request.
- **Arbitration** happens in IDLE only. A requester whose valid output is high in the current cycle is ignored.
- **Priority:** store > load > fetch. This keeps a store ahead of a load issued in the same cycle.
- **Anti-starvation counter `starve_cnt`:**
  - Increments on every load or store grant made while `ia_enable` is high.
  - When it reaches `STARVE_LIMIT`, the next arbitration grants the fetch.
  - It clears on every fetch grant.
- **States:** IDLE, READ_I, READ_D, WRITE.
- **IDLE → READ_I / READ_D / WRITE** on a grant. `mem_address` and `mem_write_data` are registered at the grant. The strobe goes low in the next cycle.
- **READ_x:**
  - `mem_read_n` stays 0 until the first cycle with `mem_data_ready_n` = 0.
  - In that cycle `mem_read_data` is captured into `iv` or `dv_in`, the strobe is released, the matching valid is set, and the state returns to IDLE.
- **WRITE:** `mem_write_n` stays 0 until `mem_data_written_n` = 0. The strobe is then released, `dv_out_valid` is set, and the state returns to IDLE.
- **Valid outputs** are registered one-cycle pulses.
- **Timeout:**
  - A counter clears on each grant and increments every cycle in a non-IDLE state.
  - At `TIMEOUT_CYCLES` the strobe is released and the owner's valid pulses anyway, with read data 0.
  - `bus_error` is set and stays set until reset.
- **Stray completions:** a `mem_data_ready_n` or `mem_data_written_n` low while in IDLE, or the wrong type for the current state, is ignored.

## Timing
- Request seen at cycle N in IDLE → strobe low at N+1.
- Memory completion at cycle M (M ≥ N+1) → valid high at M+1 → state IDLE at M+1, so re-arbitration happens at M+1.
- Minimum request-to-valid latency: 2 cycles.
- Back-to-back grants: one per 2 cycles minimum.
- Reset values (reset is asynchronous; mid-transaction it aborts immediately, with no valid pulse):
  - `mem_read_n` = `mem_write_n` = 1
  - `mem_address` = 0, `mem_write_data` = 0
  - `iv` = `dv_in` = 0
  - all valids 0, `bus_error` = 0
  - state IDLE, counters 0
- Enables arriving mid-transaction wait in place; no queueing.

## Structure
- Shared package:
  - `regval_t`, existing, 32 bits.
  - New `arb_state_t` enum {IDLE, READ_I, READ_D, WRITE}.
  - New `arb_owner_t` enum {OWN_I, OWN_D_RD, OWN_D_WR}.
- One sub-module, `arb_select`:
  - Combinational.
  - Inputs: the three masked enables and the starve-force bit.
  - Output: a one-hot grant.
- Counters and the FSM stay in `memory_arbiter`.

## Test plan
- **Single fetch:** `ia` = 0x0000_0107, `ia_enable` from cycle 0; memory completes at cycle 3 with 0xCAFE_F00D → `mem_address` = 0x104, `mem_read_n` low during cycles 1-3, `iv` = 0xCAFE_F00D with `iv_valid` pulsing at cycle 4 only.
- **Simultaneous store/load/fetch at cycle 0, each memory completion one cycle after its strobe:**
  - The store is granted first, with `mem_write_data` = `dv_out`.
  - The load follows, then the fetch.
  - Valid order: `dv_out_valid`, then `dv_in_valid`, then `iv_valid`, each pulse exactly one cycle.
- **Starvation:** `ia_enable` held high while loads are issued continuously, `STARVE_LIMIT` = 4 → exactly 4 load grants, then a fetch grant, then `starve_cnt` = 0.
- **Timeout:** `TIMEOUT_CYCLES` = 8, load issued, `mem_data_ready_n` held 1 → strobe released after 8 cycles, `dv_in_valid` pulses with `dv_in` = 0, `bus_error` = 1 and still 1 after 100 idle cycles.
- **Reset mid-write:** `reset_n` pulled low at the third WRITE cycle → `mem_write_n` = 1 in the same cycle (asynchronous), no `dv_out_valid`; after release, a new fetch completes normally.
- **Held enable:** `ia_enable` left high through the `iv_valid` cycle → no extra grant in the `iv_valid` cycle; a new grant occurs only if the enable is still high one cycle later.
